btn_debounce: RTL and testbench

- Fast-clock front end for each push button on the board.
- Synchronises the raw pad input and qualifies it with a counter-based debounce FSM.
- Emits a clean level `btn_stable`, which feeds the slow-clock 2 Hz edge-pulse synchroniser, plus one-cycle rise/fall strobes for fast-clock logic.

---
 rtl/btn_debounce.sv | 182 ++++++++++++++++++
 tb/tb_btn_debounce.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// btn_debounce: fast-clock front end for one push button.
// Two-flop synchroniser followed by a counter-qualified debounce FSM.
//
// Ports:
//   clk        in   fast system clock
//   rst        in   synchronous, active-high reset (clears every flop)
//   btn_raw    in   asynchronous, bouncing pad input
//   btn_stable out  debounced level, registered
//   btn_rise   out  one-cycle strobe on btn_stable 0->1
//   btn_fall   out  one-cycle strobe on btn_stable 1->0
//   btn_repeat out  one-cycle auto-repeat strobe while held
//
// Build option: define BTN_DEBOUNCE_REPEAT_EN to enable auto-repeat.
// Without it btn_repeat is tied to 0 and no repeat counter exists.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_WIDTH       = 20,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_stable,
    output logic btn_rise,
    output logic btn_fall,
    output logic btn_repeat
);

    typedef enum logic [1:0] {
        LOW,
        WAIT_HIGH,
        HIGH,
        WAIT_LOW
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    // Elaboration-time parameter sanity checks.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("btn_debounce: DEBOUNCE_CYCLES must be >= 2");
    end
    if ((DEBOUNCE_CYCLES >> CNT_WIDTH) != 0) begin : g_bad_width
        $error("btn_debounce: CNT_WIDTH too small for DEBOUNCE_CYCLES");
    end
    if (REPEAT_PERIOD == 0 || REPEAT_PERIOD > REPEAT_DELAY)
    begin : g_bad_repeat
        $error("btn_debounce: need 0 < REPEAT_PERIOD <= REPEAT_DELAY");
    end

    logic                 sync1_q;
    logic                 sync2_q;
    state_t               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 stable_q;
    logic                 rise_q;
    logic                 fall_q;

    // Metastability synchroniser; the FSM only ever looks at sync2_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce FSM with registered level and strobes. The counter is
    // cleared on every state change, so it is only ever compared for
    // equality and can never wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= LOW;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            unique case (state_q)
                LOW: begin
                    if (sync2_q) begin
                        state_q <= WAIT_HIGH;
                        cnt_q   <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!sync2_q) begin
                        state_q <= LOW;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q  <= HIGH;
                        cnt_q    <= '0;
                        stable_q <= 1'b1;
                        rise_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HIGH: begin
                    if (!sync2_q) begin
                        state_q <= WAIT_LOW;
                        cnt_q   <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (sync2_q) begin
                        state_q <= HIGH;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q  <= LOW;
                        cnt_q    <= '0;
                        stable_q <= 1'b0;
                        fall_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= LOW;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign btn_stable = stable_q;
    assign btn_rise   = rise_q;
    assign btn_fall   = fall_q;

`ifdef BTN_DEBOUNCE_REPEAT_EN
    localparam int unsigned RW = CNT_WIDTH + 6;
    localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_DELAY - 1);
    // After each strobe the count is reloaded so that it reaches
    // REP_LAST again exactly REPEAT_PERIOD cycles later.
    localparam logic [RW-1:0] REP_RELOAD =
        RW'(REPEAT_DELAY - REPEAT_PERIOD);

    logic          enter_high;
    logic          enter_low;
    logic [RW-1:0] rep_cnt_q;
    logic          rep_q;

    assign enter_high =
        (state_q == WAIT_HIGH && sync2_q && cnt_q == CNT_LAST) ||
        (state_q == WAIT_LOW && sync2_q);
    assign enter_low =
        (state_q == WAIT_LOW && !sync2_q && cnt_q == CNT_LAST);

    // Entering LOW wins over a coincident repeat so that btn_fall and
    // btn_repeat can never be high in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt_q <= '0;
            rep_q     <= 1'b0;
        end else begin
            rep_q <= 1'b0;
            if (enter_high) begin
                rep_cnt_q <= '0;
            end else if (state_q == HIGH || state_q == WAIT_LOW) begin
                if (enter_low) begin
                    rep_cnt_q <= '0;
                end else if (rep_cnt_q == REP_LAST) begin
                    rep_q     <= 1'b1;
                    rep_cnt_q <= REP_RELOAD;
                end else begin
                    rep_cnt_q <= rep_cnt_q + 1'b1;
                end
            end
        end
    end

    assign btn_repeat = rep_q;
`else
    assign btn_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: scoreboard bench for btn_debounce.
// Stimulus queues expected strobes; a negedge monitor pops and checks.
module tb_btn_debounce;

    localparam int DC = 4;
    localparam int CW = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    localparam logic [2:0] K_RISE = 3'b100;
    localparam logic [2:0] K_FALL = 3'b010;
    localparam logic [2:0] K_REP  = 3'b001;

    typedef struct {
        int         at;
        logic [2:0] kind;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_raw = 1'b0;
    logic btn_stable;
    logic btn_rise;
    logic btn_fall;
    logic btn_repeat;

    int total = 0;
    int bad = 0;
    int edge_n = 0;
    ev_t exp_q[$];

    btn_debounce #(
        .DEBOUNCE_CYCLES(DC),
        .CNT_WIDTH(CW),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_raw(btn_raw),
        .btn_stable(btn_stable),
        .btn_rise(btn_rise),
        .btn_fall(btn_fall),
        .btn_repeat(btn_repeat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (edge %0d)",
                     name, act, req, edge_n);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_ev(input int at, input logic [2:0] kind);
        ev_t e;
        e.at = at;
        e.kind = kind;
        exp_q.push_back(e);
    endtask

    // Monitor: every strobe must match the head of the queue.
    always @(negedge clk) begin
        logic [2:0] k;
        ev_t e;
        k = {btn_rise, btn_fall, btn_repeat};
        if (k != 3'b000) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: got kind=%b at edge %0d want none",
                         k, edge_n);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_kind", 32'(k), 32'(e.kind));
                chk("strobe_edge", edge_n, e.at);
                if (k == K_RISE) chk("stable_on_rise", 32'(btn_stable), 1);
                if (k == K_FALL) chk("stable_on_fall", 32'(btn_stable), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int r;
        int e;

        // Reset for 2 edges with the button already held.
        btn_raw = 1'b1;
        rst = 1'b1;
        tick(1);
        chk("rst_outs_1", 32'({btn_stable, btn_rise, btn_fall, btn_repeat}), 0);
        tick(1);
        chk("rst_outs_2", 32'({btn_stable, btn_rise, btn_fall, btn_repeat}), 0);
        rst = 1'b0;
        r = edge_n;
        expect_ev(r + 7, K_RISE);
        tick(6);
        chk("rst_stable_pre", 32'(btn_stable), 0);
        tick(1);
        chk("rst_stable_post", 32'(btn_stable), 1);

        // Release.
        btn_raw = 1'b0;
        p = edge_n;
        expect_ev(p + 7, K_FALL);
        tick(10);
        chk("rel1_stable", 32'(btn_stable), 0);

        // Clean press, held 18 cycles, then release.
        btn_raw = 1'b1;
        p = edge_n;
        expect_ev(p + 7, K_RISE);
        tick(18);
        chk("press_stable", 32'(btn_stable), 1);
        btn_raw = 1'b0;
        p = edge_n;
        expect_ev(p + 7, K_FALL);
        tick(6);
        chk("release_stable_pre", 32'(btn_stable), 1);
        tick(1);
        chk("release_stable_post", 32'(btn_stable), 0);
        tick(5);

        // Bounce: 1,0,1,1,0 then low.
        btn_raw = 1'b1; tick(1);
        btn_raw = 1'b0; tick(1);
        btn_raw = 1'b1; tick(2);
        btn_raw = 1'b0; tick(15);
        chk("bounce_stable", 32'(btn_stable), 0);

        // Release bounce: 3-cycle low while HIGH.
        btn_raw = 1'b1;
        p = edge_n;
        expect_ev(p + 7, K_RISE);
        tick(10);
        btn_raw = 1'b0;
        tick(3);
        btn_raw = 1'b1;
        tick(5);
        chk("rbounce_stable", 32'(btn_stable), 1);
        btn_raw = 1'b0;
        p = edge_n;
        expect_ev(p + 7, K_FALL);
        tick(12);
        chk("rbounce_released", 32'(btn_stable), 0);

        // Reset in the middle of WAIT_HIGH.
        btn_raw = 1'b1;
        tick(4);
        rst = 1'b1;
        tick(1);
        chk("midrst_outs", 32'({btn_stable, btn_rise, btn_fall, btn_repeat}), 0);
        rst = 1'b0;
        r = edge_n;
        expect_ev(r + 7, K_RISE);
        tick(7);
        chk("midrst_stable", 32'(btn_stable), 1);
        btn_raw = 1'b0;
        p = edge_n;
        expect_ev(p + 7, K_FALL);
        tick(12);

        // Long hold: auto-repeat when enabled, silence otherwise.
        btn_raw = 1'b1;
        p = edge_n;
        e = p + 7;
        expect_ev(e, K_RISE);
`ifdef BTN_DEBOUNCE_REPEAT_EN
        for (int i = 0; i < 5; i++) expect_ev(e + 20 + 8 * i, K_REP);
`endif
        tick(57);
        chk("hold_stable", 32'(btn_stable), 1);
        btn_raw = 1'b0;
        expect_ev(e + 57, K_FALL);
        tick(25);
        chk("hold_released", 32'(btn_stable), 0);

        tick(5);
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
